// File: rtl/store_buffer_pkg.sv
// Shared types for the post-commit store buffer: entry, D-cache request/response, drain states.
package store_buffer_pkg;

  localparam int NUM_STORE_BUFFER_ENTRIES = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } store_buffer_t;

  typedef struct packed {
    logic [31:0] address;
    logic        rd_en;
    logic        wr_en;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } mem_rqst_t;

  typedef struct packed {
    logic        resp;
    logic [31:0] rdata;
  } mem_resp_t;

  // Drain FSM encoding, kept as plain constants so older tools see a simple vector.
  typedef logic [0:0] sb_state_t;
  localparam sb_state_t SB_IDLE = 1'b0;
  localparam sb_state_t SB_WAIT = 1'b1;

endpackage

// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: commit enqueue, D-cache write port, load-forward probe, status.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = NUM_STORE_BUFFER_ENTRIES
);
  localparam int PTR_W = $clog2(DEPTH);

  logic            enq_valid;
  store_buffer_t   enq_entry;
  logic            enq_ready;
  mem_rqst_t       dmem_rqst;
  mem_resp_t       dmem_resp;
  logic            ld_lookup;
  logic [31:0]     ld_address;
  logic [3:0]      ld_mask;
  logic            ld_fwd_hit;
  logic [31:0]     ld_fwd_data;
  logic            ld_stall;
  logic            sb_empty;
  logic [PTR_W:0]  sb_count;

  modport slave (
    input  enq_valid, enq_entry, dmem_resp, ld_lookup, ld_address, ld_mask,
    output enq_ready, dmem_rqst, ld_fwd_hit, ld_fwd_data, ld_stall, sb_empty, sb_count
  );

  modport master (
    output enq_valid, enq_entry, dmem_resp, ld_lookup, ld_address, ld_mask,
    input  enq_ready, dmem_rqst, ld_fwd_hit, ld_fwd_data, ld_stall, sb_empty, sb_count
  );

endinterface

// File: rtl/store_buffer_fwd.sv
// Combinational store-to-load forwarding: merges matching entries oldest to youngest.
module store_buffer_fwd
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = NUM_STORE_BUFFER_ENTRIES
) (
  input  store_buffer_t             entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]  head,
  input  logic                      lookup,
  input  logic [29:0]               line,
  input  logic [3:0]                mask,
  output logic                      hit,
  output logic                      stall,
  output logic [31:0]               data
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [3:0]       covered;
  logic [31:0]      merged;
  logic [PTR_W-1:0] idx;
  logic [3:0]       need;

  // Walk from head so later (younger) writers overwrite earlier bytes.
  always_comb begin
    covered = '0;
    merged  = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (entries[idx].valid && entries[idx].address == {line, 2'b00}) begin
        covered = covered | entries[idx].mask;
        for (int b = 0; b < 4; b++)
          if (entries[idx].mask[b]) merged[8*b +: 8] = entries[idx].wdata[8*b +: 8];
      end
    end
  end

  // Full coverage forwards; any partial overlap forces the load to retry.
  always_comb begin
    need  = lookup ? mask : 4'h0;
    hit   = (need != 4'h0) && ((need & covered) == need);
    stall = ((need & covered) != 4'h0) && !hit;
    data  = hit ? merged : 32'h0;
  end

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: in-order FIFO of committed stores drained one write at a time.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = NUM_STORE_BUFFER_ENTRIES
) (
  input  logic           clk,
  input  logic           rst_n,
  store_buffer_if.slave  sb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  store_buffer_t    entries_q [DEPTH];
  store_buffer_t    entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  sb_state_t        state_q, state_d;
  mem_rqst_t        rqst_q, rqst_d;
  logic             enq_write, pop;
  logic             unused_ok;

  // Valid bit of the incoming entry, its byte offset and read data are not needed here.
  assign unused_ok = ^{sb.enq_entry.valid, sb.enq_entry.address[1:0], sb.dmem_resp.rdata};

  assign sb.enq_ready = (count_q != CNT_W'(DEPTH));
  assign sb.dmem_rqst = rqst_q;
  assign sb.sb_count  = count_q;
  assign sb.sb_empty  = (count_q == '0) && (state_q == SB_IDLE);

  // FIFO update and drain FSM; a zero-mask store is accepted but leaves no entry.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    state_d   = state_q;
    rqst_d    = rqst_q;
    enq_write = sb.enq_valid && sb.enq_ready && (sb.enq_entry.mask != 4'h0);
    pop       = (state_q == SB_WAIT) && sb.dmem_resp.resp;
    if (pop) begin
      entries_d[head_q] = '0;
      head_d            = head_q + PTR_W'(1);
    end
    if (enq_write) begin
      entries_d[tail_q] = '{valid: 1'b1,
                            address: {sb.enq_entry.address[31:2], 2'b00},
                            wdata: sb.enq_entry.wdata,
                            mask: sb.enq_entry.mask};
      tail_d            = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(enq_write) - CNT_W'(pop);
    case (state_q)
      SB_IDLE: begin
        if (count_q != '0) begin
          rqst_d = '{address: entries_q[head_q].address, rd_en: 1'b0, wr_en: 1'b1,
                     mask: entries_q[head_q].mask, wdata: entries_q[head_q].wdata};
          state_d = SB_WAIT;
        end
      end
      default: begin
        if (sb.dmem_resp.resp) begin
          rqst_d  = '0;
          state_d = SB_IDLE;
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= SB_IDLE;
      rqst_q  <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      state_q   <= state_d;
      rqst_q    <= rqst_d;
    end
  end

  store_buffer_fwd #(.DEPTH(DEPTH)) u_fwd (
    .entries (entries_q),
    .head    (head_q),
    .lookup  (sb.ld_lookup),
    .line    (sb.ld_address[31:2]),
    .mask    (sb.ld_mask),
    .hit     (sb.ld_fwd_hit),
    .stall   (sb.ld_stall),
    .data    (sb.ld_fwd_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=2).
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  store_buffer_if #(.DEPTH(2)) sb ();

  store_buffer #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] m);
    sb.enq_valid = 1'b1;
    sb.enq_entry = '{valid: 1'b0, address: addr, wdata: data, mask: m};
  endtask

  task automatic drain_all(input string name);
    int cyc;
    cyc = 0;
    sb.enq_valid = 1'b0;
    while (!sb.sb_empty && cyc < 40) begin
      sb.dmem_resp.resp = sb.dmem_rqst.wr_en;
      tick();
      cyc++;
    end
    sb.dmem_resp.resp = 1'b0;
    n_checks++;
    if (sb.sb_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: sb_empty=%0b required 1", name, sb.sb_empty);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (sb.sb_count !== 2'd0 || sb.sb_empty !== 1'b1 || sb.enq_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_status: count=%0d empty=%0b ready=%0b required 0/1/1",
               sb.sb_count, sb.sb_empty, sb.enq_ready);
    end
    n_checks++;
    if (sb.dmem_rqst !== '0 || sb.ld_fwd_hit !== 1'b0 || sb.ld_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: rqst=%h hit=%0b stall=%0b required 0", sb.dmem_rqst,
               sb.ld_fwd_hit, sb.ld_stall);
    end
    // Get into SB_WAIT, then reset mid-drain and send a stale resp.
    set_enq(32'h400, 32'h1234_5678, 4'hF);
    tick();
    sb.enq_valid = 1'b0;
    tick();
    n_checks++;
    if (sb.dmem_rqst.wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_wait: wr_en=%0b required 1", sb.dmem_rqst.wr_en);
    end
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    sb.dmem_resp.resp = 1'b1;
    tick();
    sb.dmem_resp.resp = 1'b0;
    n_checks++;
    if (sb.sb_count !== 2'd0 || sb.dmem_rqst !== '0 || sb.sb_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_drain: count=%0d rqst=%h empty=%0b required 0/0/1",
               sb.sb_count, sb.dmem_rqst, sb.sb_empty);
    end
  endtask

  task automatic test_single_store;
    set_enq(32'h100, 32'hDEAD_BEEF, 4'hF);
    tick();
    sb.enq_valid = 1'b0;
    n_checks++;
    if (sb.dmem_rqst.wr_en !== 1'b0 || sb.sb_count !== 2'd1) begin
      n_fail++;
      $display("FAIL single_enq: wr_en=%0b count=%0d required 0/1", sb.dmem_rqst.wr_en, sb.sb_count);
    end
    tick();
    n_checks++;
    if (sb.dmem_rqst !== '{address: 32'h100, rd_en: 1'b0, wr_en: 1'b1, mask: 4'hF,
                           wdata: 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL single_rqst: rqst=%h required addr 100 wr_en 1 mask F wdata DEADBEEF", sb.dmem_rqst);
    end
    sb.dmem_resp.resp = 1'b1;
    tick();
    sb.dmem_resp.resp = 1'b0;
    n_checks++;
    if (sb.sb_count !== 2'd0 || sb.sb_empty !== 1'b1 || sb.dmem_rqst !== '0) begin
      n_fail++;
      $display("FAIL single_pop: count=%0d empty=%0b rqst=%h required 0/1/0",
               sb.sb_count, sb.sb_empty, sb.dmem_rqst);
    end
  endtask

  task automatic test_full_and_wrap;
    set_enq(32'h10, 32'h0000_0010, 4'hF);
    tick();
    set_enq(32'h20, 32'h0000_0020, 4'hF);
    tick();
    set_enq(32'h30, 32'h0000_0030, 4'hF);
    #1;
    n_checks++;
    if (sb.enq_ready !== 1'b0 || sb.sb_count !== 2'd2 || sb.dmem_rqst.address !== 32'h10) begin
      n_fail++;
      $display("FAIL full_ready: ready=%0b count=%0d addr=%h required 0/2/10",
               sb.enq_ready, sb.sb_count, sb.dmem_rqst.address);
    end
    tick();
    n_checks++;
    if (sb.enq_ready !== 1'b0 || sb.sb_count !== 2'd2) begin
      n_fail++;
      $display("FAIL full_hold: ready=%0b count=%0d required 0/2", sb.enq_ready, sb.sb_count);
    end
    // Pop while full: the held enqueue must still be refused this edge.
    sb.dmem_resp.resp = 1'b1;
    tick();
    sb.dmem_resp.resp = 1'b0;
    n_checks++;
    if (sb.sb_count !== 2'd1 || sb.enq_ready !== 1'b1 || sb.dmem_rqst.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL full_no_bypass: count=%0d ready=%0b wr_en=%0b required 1/1/0",
               sb.sb_count, sb.enq_ready, sb.dmem_rqst.wr_en);
    end
    tick();
    sb.enq_valid = 1'b0;
    n_checks++;
    if (sb.sb_count !== 2'd2 || sb.dmem_rqst.address !== 32'h20) begin
      n_fail++;
      $display("FAIL wrap_second: count=%0d addr=%h required 2/20", sb.sb_count, sb.dmem_rqst.address);
    end
    sb.dmem_resp.resp = 1'b1;
    tick();
    sb.dmem_resp.resp = 1'b0;
    tick();
    n_checks++;
    if (sb.dmem_rqst.address !== 32'h30 || sb.dmem_rqst.wdata !== 32'h30) begin
      n_fail++;
      $display("FAIL wrap_third: addr=%h wdata=%h required 30/30", sb.dmem_rqst.address,
               sb.dmem_rqst.wdata);
    end
    drain_all("wrap");
  endtask

  task automatic test_forward_merge;
    set_enq(32'h200, 32'h0000_00AA, 4'b0001);
    tick();
    set_enq(32'h200, 32'hBBCC_0000, 4'b1100);
    tick();
    sb.enq_valid  = 1'b0;
    sb.ld_lookup  = 1'b1;
    sb.ld_address = 32'h200;
    sb.ld_mask    = 4'b1101;
    #1;
    n_checks++;
    if (sb.ld_fwd_hit !== 1'b1 || sb.ld_fwd_data !== 32'hBBCC_00AA || sb.ld_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_merge: hit=%0b data=%h stall=%0b required 1/BBCC00AA/0",
               sb.ld_fwd_hit, sb.ld_fwd_data, sb.ld_stall);
    end
    sb.ld_address = 32'h203;
    sb.ld_mask    = 4'b0010;
    #1;
    n_checks++;
    if (sb.ld_fwd_hit !== 1'b0 || sb.ld_stall !== 1'b0 || sb.ld_fwd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL fwd_uncovered: hit=%0b stall=%0b data=%h required 0/0/0",
               sb.ld_fwd_hit, sb.ld_stall, sb.ld_fwd_data);
    end
    sb.ld_lookup = 1'b0;
    sb.ld_mask   = 4'b1101;
    #1;
    n_checks++;
    if (sb.ld_fwd_hit !== 1'b0 || sb.ld_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_no_lookup: hit=%0b stall=%0b required 0/0", sb.ld_fwd_hit, sb.ld_stall);
    end
    drain_all("merge");
  endtask

  task automatic test_youngest_wins;
    set_enq(32'h500, 32'h1111_1111, 4'hF);
    tick();
    set_enq(32'h500, 32'h2222_0000, 4'b1100);
    tick();
    sb.enq_valid  = 1'b0;
    sb.ld_lookup  = 1'b1;
    sb.ld_address = 32'h500;
    sb.ld_mask    = 4'hF;
    #1;
    n_checks++;
    if (sb.ld_fwd_hit !== 1'b1 || sb.ld_fwd_data !== 32'h2222_1111) begin
      n_fail++;
      $display("FAIL fwd_youngest: hit=%0b data=%h required 1/22221111", sb.ld_fwd_hit, sb.ld_fwd_data);
    end
    sb.ld_lookup = 1'b0;
    drain_all("youngest");
  endtask

  task automatic test_partial_overlap;
    set_enq(32'h300, 32'h0000_1234, 4'b0011);
    tick();
    sb.enq_valid  = 1'b0;
    sb.ld_lookup  = 1'b1;
    sb.ld_address = 32'h300;
    sb.ld_mask    = 4'hF;
    #1;
    n_checks++;
    if (sb.ld_stall !== 1'b1 || sb.ld_fwd_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_stall: stall=%0b hit=%0b required 1/0", sb.ld_stall, sb.ld_fwd_hit);
    end
    sb.ld_address = 32'h304;
    #1;
    n_checks++;
    if (sb.ld_stall !== 1'b0 || sb.ld_fwd_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_other_word: stall=%0b hit=%0b required 0/0", sb.ld_stall, sb.ld_fwd_hit);
    end
    sb.ld_lookup = 1'b0;
    drain_all("partial");
  endtask

  task automatic test_simultaneous;
    set_enq(32'h600, 32'h0000_000A, 4'hF);
    tick();
    sb.enq_valid = 1'b0;
    tick();
    set_enq(32'h700, 32'h0000_000B, 4'hF);
    sb.dmem_resp.resp = 1'b1;
    tick();
    sb.enq_valid      = 1'b0;
    sb.dmem_resp.resp = 1'b0;
    n_checks++;
    if (sb.sb_count !== 2'd1 || sb.dmem_rqst.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_count: count=%0d wr_en=%0b required 1/0", sb.sb_count, sb.dmem_rqst.wr_en);
    end
    tick();
    n_checks++;
    if (sb.dmem_rqst.wr_en !== 1'b1 || sb.dmem_rqst.address !== 32'h700) begin
      n_fail++;
      $display("FAIL simul_issue: wr_en=%0b addr=%h required 1/700", sb.dmem_rqst.wr_en,
               sb.dmem_rqst.address);
    end
    drain_all("simul");
  endtask

  task automatic test_zero_mask_and_align;
    set_enq(32'h900, 32'hFFFF_FFFF, 4'h0);
    tick();
    sb.enq_valid = 1'b0;
    n_checks++;
    if (sb.sb_count !== 2'd0 || sb.sb_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_mask: count=%0d empty=%0b required 0/1", sb.sb_count, sb.sb_empty);
    end
    set_enq(32'h803, 32'h0000_5555, 4'b0011);
    tick();
    sb.enq_valid = 1'b0;
    tick();
    n_checks++;
    if (sb.dmem_rqst.address !== 32'h800 || sb.dmem_rqst.mask !== 4'b0011) begin
      n_fail++;
      $display("FAIL align_addr: addr=%h mask=%b required 800/0011", sb.dmem_rqst.address,
               sb.dmem_rqst.mask);
    end
    drain_all("align");
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    sb.enq_valid  = 1'b0;
    sb.enq_entry  = '0;
    sb.dmem_resp  = '0;
    sb.ld_lookup  = 1'b0;
    sb.ld_address = 32'h0;
    sb.ld_mask    = 4'h0;
    test_reset();
    test_single_store();
    test_full_and_wrap();
    test_forward_merge();
    test_youngest_wins();
    test_partial_overlap();
    test_simultaneous();
    test_zero_mask_and_align();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
